// File: rtl/regfile_write_scheduler_if.sv
// Bundle of the issue, writeback-requester and register-file write-port
// signals handled by regfile_write_scheduler.
//   slave  : the scheduler (consumes issue/A/B requests, drives grants,
//            stall, write port, scoreboard and error flag)
//   master : the environment (decode stage and the two writeback sources)
interface regfile_write_scheduler_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
);
  logic                issue_valid;
  logic                issue_wr;
  logic [ADDR_W-1:0]   issue_rd;
  logic                issue_use_rs1;
  logic                issue_use_rs2;
  logic [ADDR_W-1:0]   issue_rs1;
  logic [ADDR_W-1:0]   issue_rs2;
  logic                issue_stall;

  logic                a_valid;
  logic [ADDR_W-1:0]   a_rd;
  logic [DATA_W-1:0]   a_data;
  logic                a_ready;

  logic                b_valid;
  logic [ADDR_W-1:0]   b_rd;
  logic [DATA_W-1:0]   b_data;
  logic                b_ready;

  logic                Ctl_RegWrite_out;
  logic [ADDR_W-1:0]   Rd_out;
  logic [DATA_W-1:0]   WriteData_out;
  logic [NUM_REGS-1:0] busy;
  logic                wr_error;

  modport slave (
    input  issue_valid, issue_wr, issue_rd, issue_use_rs1, issue_use_rs2,
           issue_rs1, issue_rs2,
           a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output issue_stall, a_ready, b_ready,
           Ctl_RegWrite_out, Rd_out, WriteData_out, busy, wr_error
  );

  modport master (
    output issue_valid, issue_wr, issue_rd, issue_use_rs1, issue_use_rs2,
           issue_rs1, issue_rs2,
           a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  issue_stall, a_ready, b_ready,
           Ctl_RegWrite_out, Rd_out, WriteData_out, busy, wr_error
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port owner and per-register scoreboard.
// Two writeback sources (A: in-order pipeline, B: long-latency unit) share
// the single write port through a round-robin arbiter. A granted transfer is
// latched into a one-deep write stage and lands in the register file in the
// following cycle; the destination's busy bit clears on that same edge, so
// decode (stalled on RAW/WAW against busy) always reads current values.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : regfile_write_scheduler_if.slave (issue, A/B requests, write
//           port, busy scoreboard, sticky wr_error)
module regfile_write_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic                      clk,
  input logic                      reset,
  regfile_write_scheduler_if.slave bus
);

  typedef enum logic {FAVOR_A = 1'b0, FAVOR_B = 1'b1} rrState_t;

  rrState_t            rrState;
  logic                outValid;
  logic [ADDR_W-1:0]   rdOut;
  logic [DATA_W-1:0]   dataOut;
  logic [NUM_REGS-1:0] busyQ;
  logic [NUM_REGS-1:0] busyNext;
  logic                wrError;

  logic                aGrant;
  logic                bGrant;
  logic                xfer;
  logic [ADDR_W-1:0]   xferRd;
  logic [DATA_W-1:0]   xferData;
  logic                issueStall;
  logic                issueSet;

  always_comb begin
    aGrant   = bus.a_valid && (!bus.b_valid || (rrState == FAVOR_A));
    bGrant   = bus.b_valid && !aGrant;
    xfer     = aGrant || bGrant;
    xferRd   = aGrant ? bus.a_rd   : bus.b_rd;
    xferData = aGrant ? bus.a_data : bus.b_data;
  end

  always_comb begin
    issueStall = bus.issue_valid &&
                 ((bus.issue_use_rs1 && busyQ[bus.issue_rs1]) ||
                  (bus.issue_use_rs2 && busyQ[bus.issue_rs2]) ||
                  (bus.issue_wr      && busyQ[bus.issue_rd]));
    issueSet   = bus.issue_valid && !issueStall && bus.issue_wr &&
                 (bus.issue_rd != '0);
  end

  // Clear for the landing write and set for a newly issued destination can
  // share an edge; WAW stalling guarantees they never target the same bit.
  always_comb begin
    busyNext = busyQ;
    if (outValid) busyNext[rdOut] = 1'b0;
    if (issueSet) busyNext[bus.issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrState  <= FAVOR_A;
      outValid <= 1'b0;
      rdOut    <= '0;
      dataOut  <= '0;
      busyQ    <= '0;
      wrError  <= 1'b0;
    end else begin
      busyQ    <= busyNext;
      outValid <= xfer;
      if (xfer) begin
        rdOut   <= xferRd;
        dataOut <= xferData;
        if ((xferRd != '0) && !busyQ[xferRd]) wrError <= 1'b1;
      end
      if (aGrant)      rrState <= FAVOR_B;
      else if (bGrant) rrState <= FAVOR_A;
    end
  end

  assign bus.issue_stall      = issueStall;
  assign bus.a_ready          = aGrant;
  assign bus.b_ready          = bGrant;
  assign bus.Ctl_RegWrite_out = outValid && (rdOut != '0);
  assign bus.Rd_out           = rdOut;
  assign bus.WriteData_out    = dataOut;
  assign bus.busy             = busyQ;
  assign bus.wr_error         = wrError;

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register file and a per-register scoreboard.
- Two writeback sources share the port: A is the in-order pipeline writeback and B is the long-latency unit (mul/div/load).
- Decode is stalled on RAW/WAW hazards until the pending write has actually landed in the register file, so combinational reads are always current.

Parameters:
- NUM_REGS, 32, architectural register count.
- ADDR_W, 5, register index width.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_wr  in  1  instruction writes a destination.
- issue_rd  in  ADDR_W  destination index.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_rs1  in  ADDR_W  source index 1.
- issue_rs2  in  ADDR_W  source index 2.
- issue_stall  out  1  combinational hazard stall.
- a_valid  in  1  requester A has a write pending.
- a_rd  in  ADDR_W  requester A destination.
- a_data  in  DATA_W  requester A data.
- a_ready  out  1  requester A granted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_rd  in  ADDR_W  requester B destination.
- b_data  in  DATA_W  requester B data.
- b_ready  out  1  requester B granted this cycle.
- Ctl_RegWrite_out  out  1  register file write enable.
- Rd_out  out  ADDR_W  register file write index.
- WriteData_out  out  DATA_W  register file write data.
- busy  out  NUM_REGS  scoreboard bits.
- wr_error  out  1  sticky: write to a non-busy register.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, Ctl_RegWrite_out=0, Rd_out=0, WriteData_out=0, wr_error=0, round-robin pointer favours A. The internal out_valid stage is cleared, and any in-flight write is dropped.
- busy[0] is hard-wired to 0.
- issue_stall = issue_valid && ((issue_use_rs1 && busy[issue_rs1]) || (issue_use_rs2 && busy[issue_rs2]) || (issue_wr && busy[issue_rd])).
- The stall is evaluated on current-cycle busy only; there is no bypass.
- Issue is accepted when issue_valid && !issue_stall. On acceptance with issue_wr and issue_rd!=0, busy[issue_rd] is set at the clock edge.
- Arbitration is combinational within the cycle:
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the side the pointer favours.
  - A transfer is valid && ready.
  - After any grant, the pointer favours the other requester.
  - At most one ready is high per cycle.
- Requesters hold valid, rd and data stable until ready. Violation is a protocol error, flagged by a bench assertion; it does not affect RTL behaviour.
- Write stage: at the transfer edge, out_valid=1 and the granted rd/data are latched. In the next cycle, Ctl_RegWrite_out = out_valid && (Rd_out!=0).
  - Latency: transfer in cycle T → register file write at the end of T+1.
- Scoreboard clear: at the edge ending T+1 (out_valid=1), busy[Rd_out] is cleared. An issue in T+2 sees busy=0, and the register file already holds the new value.
- Back-to-back transfers sustain one write per cycle. out_valid drops when no transfer occurs.
- Simultaneous set and clear on the same edge:
  - Same register is impossible, because WAW stalls the issue.
  - Different registers: both take effect.
- rd=0 transfer: the handshake completes, Ctl_RegWrite_out stays 0, and busy is unchanged.
- wr_error: set at the transfer edge when the transferred rd!=0 and busy[rd]==0. It is sticky until reset. The write is still performed.
- Reset asserted mid-operation: outputs drop immediately (asynchronous). The pending write is lost, and requesters must re-present.

Test Plan:
1. Reset low then high → all outputs 0, busy=0, wr_error=0. a_valid=b_valid=1 in the first cycle → a_ready=1, b_ready=0.
2. Cycle 0: issue rd=5. Cycle 1: issue rs1=5 → issue_stall=1. Cycle 3: A writes rd=5 with 0xDEADBEEF → a_ready=1 in cycle 3. Cycle 4: Ctl_RegWrite_out=1, Rd_out=5, WriteData_out=0xDEADBEEF. busy[5]=0 and issue_stall=0 from cycle 5.
3. busy[3]=busy[7]=1. A(rd=3) and B(rd=7) both valid and held → grants A, B on consecutive cycles. Re-present both → A granted again. Writes to 3 and 7 are seen back-to-back on the output.
4. A writes rd=0 with data 0x1234 → a_ready=1, Ctl_RegWrite_out=0 the next cycle, busy unchanged, wr_error=0.
5. B writes rd=9 while busy[9]=0 → write occurs (Rd_out=9 the next cycle), wr_error=1 and remains 1 until reset.
6. Transfer in cycle T, then reset pulsed low mid-cycle T+1 → Ctl_RegWrite_out falls before the next edge, busy=0, and no write is seen after reset releases.
